// File: rtl/adder_check_pkg.sv
// Shared types and default sizing for the exhaustive adder stimulus/checker.
package adder_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF     = 4;
    localparam int HOLD_DEF  = 1;
    localparam int ERR_W_DEF = 16;

endpackage

// File: rtl/adder_stim_checker.sv
// Sweeps every {op_a, op_b} pair, compares the DUT sum against the golden sum
// on the last cycle of each hold window, and reports a saturating error count.
module adder_stim_checker
    import adder_check_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int HOLD  = HOLD_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    input  logic [N:0]       dut_sum,
    input  logic [N:0]       ref_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N-1:0]     fail_a,
    output logic [N-1:0]     fail_b
);

    localparam int            VW        = 2 * N;
    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    state_t           r_state,  w_state_nxt;
    logic [VW-1:0]    r_vec,    w_vec_nxt;
    logic [HW-1:0]    r_hold,   w_hold_nxt;
    logic [ERR_W-1:0] r_err,    w_err_nxt;
    logic [N-1:0]     r_fail_a, w_fail_a_nxt;
    logic [N-1:0]     r_fail_b, w_fail_b_nxt;
    logic             r_pass,   w_pass_nxt;

    logic             w_cmp;
    logic             w_mismatch;
    logic             w_last_vec;
    logic             w_err_sat;

    // Sums are only trusted on the final cycle of a hold window.
    assign w_cmp      = (r_state == RUN) && (r_hold == HOLD_LAST);
    assign w_mismatch = w_cmp && (dut_sum != ref_sum);
    assign w_last_vec = &r_vec;
    assign w_err_sat  = &r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_vec_nxt    = r_vec;
        w_hold_nxt   = r_hold;
        w_err_nxt    = r_err;
        w_fail_a_nxt = r_fail_a;
        w_fail_b_nxt = r_fail_b;
        w_pass_nxt   = r_pass;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt  = RUN;
                    w_vec_nxt    = '0;
                    w_hold_nxt   = '0;
                    w_err_nxt    = '0;
                    w_fail_a_nxt = '0;
                    w_fail_b_nxt = '0;
                    w_pass_nxt   = 1'b0;
                end
            end

            RUN: begin
                if (w_cmp) begin
                    if (w_mismatch) begin
                        if (!w_err_sat) begin
                            w_err_nxt = r_err + ERR_W'(1);
                        end
                        if (r_err == '0) begin
                            w_fail_a_nxt = r_vec[VW-1:N];
                            w_fail_b_nxt = r_vec[N-1:0];
                        end
                    end
                    w_hold_nxt = '0;
                    // Last vector: operands stay on the final pair for inspection.
                    if (w_last_vec) begin
                        w_state_nxt = DONE;
                        w_pass_nxt  = (w_err_nxt == '0);
                    end else begin
                        w_vec_nxt = r_vec + VW'(1);
                    end
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_hold   <= '0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vec    <= w_vec_nxt;
            r_hold   <= w_hold_nxt;
            r_err    <= w_err_nxt;
            r_fail_a <= w_fail_a_nxt;
            r_fail_b <= w_fail_b_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign op_a      = r_vec[VW-1:N];
    assign op_b      = r_vec[N-1:0];
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Scoreboard bench: two checker instances (HOLD=1/ERR_W=16 and HOLD=3/ERR_W=2)
// driven by faulty/correct adder models, with expected reports queued per sweep.
module tb_adder_stim_checker;

    localparam int N = 2;
    localparam int M = 1 << N;
    localparam int V = 1 << (2 * N);

    typedef struct {
        int err;
        int fa;
        int fb;
        int pass;
        int cycles;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [1:0]   start;
    logic [N-1:0] opa   [2];
    logic [N-1:0] opb   [2];
    logic [N:0]   dsum  [2];
    logic [N:0]   rsum  [2];
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   pass;
    logic [15:0]  errc  [2];
    logic [N-1:0] fa    [2];
    logic [N-1:0] fb    [2];

    int           mode   [2];
    bit           glitch [2];
    logic [N:0]   corrupt [2][V];

    int   n_chk;
    int   n_fail;
    exp_t q0[$];
    exp_t q1[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int HG = (g == 0) ? 1 : 3;
        localparam int EG = (g == 0) ? 16 : 2;
        logic [EG-1:0] err_w;
        adder_stim_checker #(.N(N), .HOLD(HG), .ERR_W(EG)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .op_a      (opa[g]),
            .op_b      (opb[g]),
            .dut_sum   (dsum[g]),
            .ref_sum   (rsum[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .err_count (err_w),
            .fail_a    (fa[g]),
            .fail_b    (fb[g])
        );
        assign errc[g] = 16'(err_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Adder under test behaviour: 0 correct, 1 carry stuck at 0, 2 always 0, 3 random corruption.
    function automatic int sum_model(input int md, input int a, input int b, input int c);
        case (md)
            1:       return (a + b) % M;
            2:       return 0;
            3:       return (a + b) ^ c;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            rsum[g] = (N+1)'(int'(opa[g]) + int'(opb[g]));
            dsum[g] = (N+1)'(sum_model(mode[g], int'(opa[g]), int'(opb[g]),
                                       int'(corrupt[g][{opa[g], opb[g]}])))
                      ^ (glitch[g] ? {(N+1){1'b1}} : {(N+1){1'b0}});
        end
    end

    function automatic exp_t model(input int g, input int md);
        exp_t e;
        int   lim;
        lim      = (g == 0) ? 65535 : 3;
        e.err    = 0;
        e.fa     = 0;
        e.fb     = 0;
        for (int v = 0; v < V; v++) begin
            int a;
            int b;
            a = v / M;
            b = v % M;
            if (sum_model(md, a, b, int'(corrupt[g][v])) != a + b) begin
                if (e.err == 0) begin
                    e.fa = a;
                    e.fb = b;
                end
                if (e.err < lim) e.err++;
            end
        end
        e.pass   = (e.err == 0) ? 1 : 0;
        e.cycles = V * hold_of(g);
        return e;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic check_zero(input int g);
        chk("rst_op_a",  int'(opa[g]),  0);
        chk("rst_op_b",  int'(opb[g]),  0);
        chk("rst_busy",  int'(busy[g]), 0);
        chk("rst_done",  int'(done[g]), 0);
        chk("rst_pass",  int'(pass[g]), 0);
        chk("rst_err",   int'(errc[g]), 0);
        chk("rst_fail_a", int'(fa[g]),  0);
        chk("rst_fail_b", int'(fb[g]),  0);
    endtask

    task automatic sweep(input int g, input int md, input bit gl);
        exp_t e;
        int   h;
        int   total;
        h     = hold_of(g);
        total = V * h;
        mode[g] = md;
        for (int v = 0; v < V; v++)
            corrupt[g][v] = ($urandom_range(0, 3) == 0) ? (N+1)'($urandom_range(7, 1)) : '0;
        e = model(g, md);
        if (g == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        chk("start_busy",   int'(busy[g]), 1);
        chk("start_err",    int'(errc[g]), 0);
        chk("start_fail_a", int'(fa[g]),   0);
        chk("start_fail_b", int'(fb[g]),   0);
        chk("start_pass",   int'(pass[g]), 0);
        for (int j = 1; j <= total; j++) begin
            glitch[g] = gl && ((j % h) != 0);
            chk("op_vec", int'({opa[g], opb[g]}), (j - 1) / h);
            @(posedge clk); #1;
        end
        glitch[g] = 1'b0;
        chk("op_last", int'({opa[g], opb[g]}), V - 1);
    endtask

    // Monitor: pops one expected report each time a checker enters DONE.
    initial begin
        int  bcnt [2];
        bit  dprev[2];
        exp_t e;
        bcnt  = '{0, 0};
        dprev = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) bcnt[g] = 0;
                else if (busy[g]) bcnt[g]++;
                chk("pass_only_in_done", int'(pass[g] & ~done[g]), 0);
                if (done[g] && !dprev[g]) begin
                    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done: inst %0d done with no expected report", g);
                    end else begin
                        if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk("done_err_count", int'(errc[g]), e.err);
                        chk("done_fail_a",    int'(fa[g]),   e.fa);
                        chk("done_fail_b",    int'(fb[g]),   e.fb);
                        chk("done_pass",      int'(pass[g]), e.pass);
                        chk("run_cycles",     bcnt[g],       e.cycles);
                    end
                    bcnt[g] = 0;
                end
                dprev[g] = done[g];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 2'b00;
        mode      = '{0, 0};
        glitch    = '{1'b0, 1'b0};
        for (int g = 0; g < 2; g++)
            for (int v = 0; v < V; v++) corrupt[g][v] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check_zero(g);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Correct adder: full pass, operands left on 3/3.
        sweep(0, 0, 1'b0);
        @(negedge clk);
        chk("t1_pass", int'(pass[0]), 1);
        chk("t1_done", int'(done[0]), 1);

        // Carry-out stuck at 0.
        sweep(0, 1, 1'b0);
        @(negedge clk);
        chk("t2_err",    int'(errc[0]), 6);
        chk("t2_fail_a", int'(fa[0]),   1);
        chk("t2_fail_b", int'(fb[0]),   3);
        chk("t2_pass",   int'(pass[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_hold_done", int'(done[0]), 1);
        chk("t2_hold_err",  int'(errc[0]), 6);

        // Restart straight out of DONE with a random fault pattern.
        sweep(0, 3, 1'b0);

        // HOLD=3 with glitches outside compare cycles.
        sweep(1, 0, 1'b1);
        @(negedge clk);
        chk("t3_err",  int'(errc[1]), 0);
        chk("t3_pass", int'(pass[1]), 1);

        // Always-zero adder saturates a 2-bit counter.
        sweep(1, 2, 1'b0);
        @(negedge clk);
        chk("t4_err",    int'(errc[1]), 3);
        chk("t4_fail_a", int'(fa[1]),   0);
        chk("t4_fail_b", int'(fb[1]),   1);

        for (int k = 0; k < 6; k++)
            sweep(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Start held through RUN, then reset at vector 5.
        mode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= 5; j++) begin
            chk("t5_busy", int'(busy[0]), 1);
            chk("t5_vec",  int'({opa[0], opb[0]}), j - 1);
            @(posedge clk); #1;
        end
        chk("t5_vec5", int'({opa[0], opb[0]}), 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) check_zero(g);
        rst_n    = 1'b1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle_busy", int'(busy[0]), 0);
        sweep(0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
